// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display arbiter: FSM state encoding, display
// geometry (4 digits of 4 bits) and the width helper for the hold counter.
// -----------------------------------------------------------------------------
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_e;

   localparam int DIGITS   = 4;
   localparam int NIBBLE_W = 4;
   localparam int DATA_W   = DIGITS * NIBBLE_W;

   // Width of a counter able to hold HOLD_CYCLES-1; never narrower than 1 bit.
   function automatic int cnt_width(input int hold);
      int w;
      w = $clog2(hold);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage : display_pkg

// File: rtl/hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Minimum-ownership timer. Loading presets the counter to HOLD_CYCLES-1; it
// then counts down once per cycle and saturates at zero.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset (counter cleared to 0)
//   load_i  - preset counter to HOLD_CYCLES-1 this cycle
//   zero_o  - counter currently at zero
// -----------------------------------------------------------------------------
module hold_timer
   import display_pkg::*;
#(
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   output logic zero_o
);

   localparam int              CNT_W    = cnt_width(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign zero_o = (cnt_q == CNT_ZERO);

   // Next count: load has priority, otherwise saturating decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (!zero_o) begin
         cnt_d = cnt_q - CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : hold_timer

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
// Arbitrates a 4-digit 7-segment display between two requesters. The owner
// keeps the display for at least HOLD_CYCLES cycles; ties and hand-overs are
// decided round-robin so neither requester starves.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   req_a_i/data_a_i/dots_a_i - requester A: request, digits ([15:12] left),
//                              decimal points ([3] left)
//   req_b_i/data_b_i/dots_b_i - requester B, same layout
//   gnt_a_o, gnt_b_o         - current owner (one-hot or none)
//   busy_o                   - display owned by someone
//   hex_1_o..hex_4_o         - digits to display driver, hex_1 leftmost
//   dot_1_o..dot_4_o         - decimal points, dot_1 leftmost
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module display_arbiter
   import display_pkg::*;
#(
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_a_i,
   input  logic [DATA_W-1:0] data_a_i,
   input  logic [DIGITS-1:0] dots_a_i,
   input  logic              req_b_i,
   input  logic [DATA_W-1:0] data_b_i,
   input  logic [DIGITS-1:0] dots_b_i,
   output logic              gnt_a_o,
   output logic              gnt_b_o,
   output logic              busy_o,
   output logic [NIBBLE_W-1:0] hex_1_o,
   output logic [NIBBLE_W-1:0] hex_2_o,
   output logic [NIBBLE_W-1:0] hex_3_o,
   output logic [NIBBLE_W-1:0] hex_4_o,
   output logic              dot_1_o,
   output logic              dot_2_o,
   output logic              dot_3_o,
   output logic              dot_4_o
);

   state_e            state_q, state_d;
   logic              fav_b_q, fav_b_d;   // 1: B wins the next tie
   logic              gnt_a_q, gnt_a_d;
   logic              gnt_b_q, gnt_b_d;
   logic              busy_q,  busy_d;
   logic [DATA_W-1:0] hex_q,   hex_d;
   logic [DIGITS-1:0] dot_q,   dot_d;
   logic              load_s;
   logic              zero_s;

   hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load_s),
      .zero_o (zero_s)
   );

   // Next-state, hold-timer load, round-robin pointer and display data.
   always_comb begin
      state_d = state_q;
      fav_b_d = fav_b_q;
      hex_d   = hex_q;
      dot_d   = dot_q;
      load_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_a_i && (!req_b_i || !fav_b_q)) begin
               state_d = ST_OWN_A;
               load_s  = 1'b1;
               fav_b_d = 1'b1;
               hex_d   = data_a_i;
               dot_d   = dots_a_i;
            end else if (req_b_i) begin
               state_d = ST_OWN_B;
               load_s  = 1'b1;
               fav_b_d = 1'b0;
               hex_d   = data_b_i;
               dot_d   = dots_b_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN_A: begin
            if (!zero_s) begin
               // Minimum hold not yet served: ownership is locked.
               if (req_a_i) begin
                  hex_d = data_a_i;
                  dot_d = dots_a_i;
               end else begin
                  hex_d = hex_q;
               end
            end else if (req_b_i) begin
               // Direct hand-over, no IDLE bubble.
               state_d = ST_OWN_B;
               load_s  = 1'b1;
               fav_b_d = 1'b0;
               hex_d   = data_b_i;
               dot_d   = dots_b_i;
            end else if (req_a_i) begin
               load_s = 1'b1;
               hex_d  = data_a_i;
               dot_d  = dots_a_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN_B: begin
            if (!zero_s) begin
               if (req_b_i) begin
                  hex_d = data_b_i;
                  dot_d = dots_b_i;
               end else begin
                  hex_d = hex_q;
               end
            end else if (req_a_i) begin
               state_d = ST_OWN_A;
               load_s  = 1'b1;
               fav_b_d = 1'b1;
               hex_d   = data_a_i;
               dot_d   = dots_a_i;
            end else if (req_b_i) begin
               load_s = 1'b1;
               hex_d  = data_b_i;
               dot_d  = dots_b_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            fav_b_d = 1'b0;
         end
      endcase
      gnt_a_d = (state_d == ST_OWN_A);
      gnt_b_d = (state_d == ST_OWN_B);
      busy_d  = gnt_a_d | gnt_b_d;
   end

   // State, pointer, grant and display registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fav_b_q <= 1'b0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         busy_q  <= 1'b0;
         hex_q   <= {DATA_W{1'b0}};
         dot_q   <= {DIGITS{1'b0}};
      end else begin
         state_q <= state_d;
         fav_b_q <= fav_b_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         busy_q  <= busy_d;
         hex_q   <= hex_d;
         dot_q   <= dot_d;
      end
   end

   assign gnt_a_o = gnt_a_q;
   assign gnt_b_o = gnt_b_q;
   assign busy_o  = busy_q;
   assign hex_1_o = hex_q[15:12];
   assign hex_2_o = hex_q[11:8];
   assign hex_3_o = hex_q[7:4];
   assign hex_4_o = hex_q[3:0];
   assign dot_1_o = dot_q[3];
   assign dot_2_o = dot_q[2];
   assign dot_3_o = dot_q[1];
   assign dot_4_o = dot_q[0];

endmodule : display_arbiter
